proc_core_p: RTL

PROC_CORE_P -- requirements
Module: proc_core_p

---
 rtl/proc_core_p.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/proc_core_p.sv
// proc_core_p: two-phase (ph1/ph2) multi-cycle core with FETCH/EXEC/MEM/HALT sequencing.
// Define PROC_CORE_P_INSTRET_EN to build the 32-bit retired-instruction counter.
module proc_core_p #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 8,
  parameter int NREGS  = 16
) (
  input  logic              ph1,
  input  logic              ph2,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  input  logic [WIDTH-1:0]  mem_rdata,
  input  logic              mem_ready,
  output logic              halted,
  output logic [31:0]       instret
);
  localparam int RW = $clog2(NREGS);
  localparam logic [3:0] OP_HALT  = 4'd0,  OP_SETN  = 4'd1,  OP_LOAD  = 4'd2,  OP_STORE = 4'd3;
  localparam logic [3:0] OP_ADD   = 4'd4,  OP_SUB   = 4'd5,  OP_JUMPN = 4'd6,  OP_JEQZN = 4'd7;
  localparam logic [3:0] OP_JNEZN = 4'd8,  OP_JGTZN = 4'd9,  OP_JLTZN = 4'd10, OP_JUMPR = 4'd11;

  typedef enum logic [1:0] {FETCH = 2'd0, EXEC = 2'd1, MEM = 2'd2, HALT = 2'd3} state_t;

  state_t            state;
  logic [15:0]       ir;
  logic [ADDR_W-1:0] pc, pc_inc, imm_pc, next_pc;
  logic [WIDTH-1:0]  regs [NREGS];
  logic              ready_m;
  logic [WIDTH-1:0]  rdata_m;
  logic [3:0]        op;
  logic [RW-1:0]     rd_i, ra_i, rb_i, rf_wa;
  logic [7:0]        imm;
  logic [WIDTH-1:0]  rd_v, ra_v, rb_v, alu, rf_wd;
  logic              take, alu_we, rf_we;

  assign op     = ir[15:12];
  assign rd_i   = ir[8 +: RW];
  assign ra_i   = ir[4 +: RW];
  assign rb_i   = ir[0 +: RW];
  assign imm    = ir[7:0];
  assign rd_v   = (rd_i == {RW{1'b0}}) ? {WIDTH{1'b0}} : regs[rd_i];
  assign ra_v   = (ra_i == {RW{1'b0}}) ? {WIDTH{1'b0}} : regs[ra_i];
  assign rb_v   = (rb_i == {RW{1'b0}}) ? {WIDTH{1'b0}} : regs[rb_i];
  assign pc_inc = pc + {{(ADDR_W-1){1'b0}}, 1'b1};
  assign imm_pc = ADDR_W'(imm);

  // Master phase: memory handshake and data are captured on ph1, consumed on ph2.
  always_ff @(posedge ph1) begin
    ready_m <= mem_ready;
    rdata_m <= mem_rdata;
  end

  // Execute-stage decode: ALU result, register write enable and branch target.
  always_comb begin
    take   = 1'b0;
    alu    = ra_v;
    alu_we = 1'b0;
    case (op)
      OP_SETN:  begin alu = {{(WIDTH-8){imm[7]}}, imm}; alu_we = 1'b1; end
      OP_ADD:   begin alu = ra_v + rb_v; alu_we = 1'b1; end
      OP_SUB:   begin alu = ra_v - rb_v; alu_we = 1'b1; end
      OP_JUMPN: take = 1'b1;
      OP_JEQZN: take = (rd_v == {WIDTH{1'b0}});
      OP_JNEZN: take = (rd_v != {WIDTH{1'b0}});
      OP_JGTZN: take = !rd_v[WIDTH-1] && (rd_v != {WIDTH{1'b0}});
      OP_JLTZN: take = rd_v[WIDTH-1];
      default:  take = 1'b0;
    endcase
    if (op == OP_JUMPR) next_pc = rd_v[ADDR_W-1:0];
    else if (take)      next_pc = imm_pc;
    else                next_pc = pc_inc;
  end

  // Register-file write port: ALU results in EXEC, load data on MEM completion.
  always_comb begin
    rf_we = 1'b0;
    rf_wa = rd_i;
    rf_wd = alu;
    if (state == EXEC) begin
      rf_we = alu_we;
    end else if ((state == MEM) && ready_m && !mem_we) begin
      rf_we = 1'b1;
      rf_wd = rdata_m;
    end else begin
      rf_we = 1'b0;
    end
  end

  // Slave phase register-file write; r0 is never stored.
  always_ff @(posedge ph2) begin
    if (!reset && rf_we && (rf_wa != {RW{1'b0}})) regs[rf_wa] <= rf_wd;
  end

  // Control FSM with registered memory-port outputs; a request stays frozen until mem_ready.
  always_ff @(posedge ph2) begin
    if (reset) begin
      state     <= FETCH;
      pc        <= {ADDR_W{1'b0}};
      ir        <= 16'h0000;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= {ADDR_W{1'b0}};
      mem_wdata <= {WIDTH{1'b0}};
      halted    <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pc;
          end else if (ready_m) begin
            ir      <= rdata_m[15:0];
            mem_req <= 1'b0;
            state   <= EXEC;
          end
        end
        EXEC: begin
          case (op)
            OP_HALT: begin
              halted <= 1'b1;
              state  <= HALT;
            end
            OP_LOAD, OP_STORE: begin
              mem_req   <= 1'b1;
              mem_we    <= (op == OP_STORE);
              mem_addr  <= ra_v[ADDR_W-1:0];
              mem_wdata <= rd_v;
              state     <= MEM;
            end
            default: begin
              pc       <= next_pc;
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= next_pc;
              state    <= FETCH;
            end
          endcase
        end
        MEM: begin
          if (ready_m) begin
            pc       <= pc_inc;
            mem_we   <= 1'b0;
            mem_addr <= pc_inc;
            state    <= FETCH;
          end
        end
        HALT:    state <= HALT;
        default: state <= FETCH;
      endcase
    end
  end

`ifdef PROC_CORE_P_INSTRET_EN
  logic        retire;
  logic [31:0] instret_q;
  assign retire = ((state == EXEC) && (op != OP_HALT) && (op != OP_LOAD) && (op != OP_STORE)) ||
                  ((state == MEM) && ready_m);

  // Retired-instruction counter, wraps at 2^32.
  always_ff @(posedge ph2) begin
    if (reset)       instret_q <= 32'd0;
    else if (retire) instret_q <= instret_q + 32'd1;
  end
  assign instret = instret_q;
`else
  assign instret = 32'd0;
`endif
endmodule
